// File: rtl/clock_mode_ctrl_pkg.sv
// Shared types and defaults for the clock mode controller: state encodings,
// default timing parameters and the counter-width helper.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    EDIT_H = 2'b01,
    EDIT_M = 2'b10,
    EDIT_S = 2'b11
  } mode_e;

  localparam int unsigned DEF_CLK_DIV    = 100_000_000;
  localparam int unsigned DEF_REPEAT_DLY = 50_000_000;
  localparam int unsigned DEF_REPEAT_PER = 12_500_000;
  localparam int unsigned DEF_BLINK_DIV  = 25_000_000;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      RUN:     return EDIT_H;
      EDIT_H:  return EDIT_M;
      EDIT_M:  return EDIT_S;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Button inputs and clock-control outputs of the mode controller.
interface clock_mode_ctrl_if;
  import clock_ctrl_pkg::*;

  logic  ModeBtn;
  logic  IncBtn;
  logic  SecTick;
  logic  EditHours;
  logic  EditMinutes;
  logic  EditSeconds;
  logic  Increment;
  logic  Blink;
  mode_e Mode;

  modport master (
    output ModeBtn, IncBtn,
    input  SecTick, EditHours, EditMinutes, EditSeconds, Increment, Blink, Mode
  );

  modport slave (
    input  ModeBtn, IncBtn,
    output SecTick, EditHours, EditMinutes, EditSeconds, Increment, Blink, Mode
  );
endinterface

// File: rtl/btn_autorepeat.sv
// Rising-edge detector with hold-to-repeat: one pulse on press, another after
// REPEAT_DLY cycles of holding, then one every REPEAT_PER cycles.
module btn_autorepeat
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER = DEF_REPEAT_PER
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  input  logic enable,
  input  logic clear,
  output logic pulse
);

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned CW      = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

  logic          btn_prev;
  logic          active;
  logic          first;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          due;

  assign rise = btn & ~btn_prev;
  assign due  = active && (cnt == (first ? DLY_LAST : PER_LAST));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the later pulse <= 1'b1 overrides the default.
  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_prev <= 1'b1;  // a button held through reset must not look like a press
      active   <= 1'b0;
      first    <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      btn_prev <= btn;
      pulse    <= 1'b0;
      if (clear || !enable || !btn) begin
        active <= 1'b0;
        first  <= 1'b0;
        cnt    <= '0;
      end else if (rise) begin
        active <= 1'b1;
        first  <= 1'b1;
        cnt    <= '0;
        pulse  <= 1'b1;
      end else if (due) begin
        first  <= 1'b0;
        cnt    <= '0;
        pulse  <= 1'b1;
      end else if (active) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Clock set/run controller: mode FSM, seconds prescaler, edit-field blink and
// increment auto-repeat for a digital clock.
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER = DEF_REPEAT_PER,
  parameter int unsigned BLINK_DIV  = DEF_BLINK_DIV
) (
  input  logic              CLK,
  input  logic              RST,
  clock_mode_ctrl_if.slave  bus
);

  localparam int unsigned PW = cnt_width(CLK_DIV);
  localparam int unsigned BW = cnt_width(BLINK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  mode_e         state;
  logic          mode_prev;
  logic          mode_rise;
  logic          run_stay;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic          sec_tick;
  logic          blink;
  logic [BW-1:0] blink_cnt;

  assign mode_rise = bus.ModeBtn & ~mode_prev;
  assign run_stay  = (state == RUN) && !mode_rise;

  // NOTE: default assignment first so no path leaves presc_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    presc_next = '0;
    if (run_stay) presc_next = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      mode_prev <= 1'b1;
      presc     <= '0;
      sec_tick  <= 1'b0;
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else begin
      mode_prev <= bus.ModeBtn;
      presc     <= presc_next;
      // Tick register mirrors the prescaler so it is high while presc == CLK_DIV-1.
      sec_tick  <= run_stay && (presc_next == PRESC_LAST);
      if (mode_rise) begin
        state     <= next_mode(state);
        blink     <= 1'b1;
        blink_cnt <= '0;
      end else if (state == RUN) begin
        blink     <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // A mode change clears any pending repeat, so a held button needs a new press.
  btn_autorepeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_inc_repeat (
    .CLK    (CLK),
    .RST    (RST),
    .btn    (bus.IncBtn),
    .enable (state != RUN),
    .clear  (mode_rise),
    .pulse  (bus.Increment)
  );

  assign bus.Mode        = state;
  assign bus.EditHours   = (state == EDIT_H);
  assign bus.EditMinutes = (state == EDIT_M);
  assign bus.EditSeconds = (state == EDIT_S);
  assign bus.SecTick     = sec_tick;
  assign bus.Blink       = blink;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus random button activity,
// every cycle compared against a cycle-count reference model.
module tb_clock_mode_ctrl;
  import clock_ctrl_pkg::*;

  localparam int CLK_DIV    = 10;
  localparam int REPEAT_DLY = 8;
  localparam int REPEAT_PER = 3;
  localparam int BLINK_DIV  = 4;

  logic CLK = 1'b0;
  logic RST;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: mode as press count mod 4, times measured in cycles since
  // the relevant event (RUN entry, edit entry, IncBtn press).
  int   m_mode;
  int   m_run_n;
  int   m_edit_n;
  int   m_press;   // cycles since the IncBtn edge cycle, -1 when no live press
  logic m_pm;
  logic m_pi;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tick();
    return (m_mode == 0) && ((m_run_n % CLK_DIV) == CLK_DIV - 1);
  endfunction

  function automatic logic exp_inc();
    return (m_press == 1) ||
           (m_press >= 1 + REPEAT_DLY && ((m_press - 1 - REPEAT_DLY) % REPEAT_PER) == 0);
  endfunction

  function automatic logic exp_blink();
    return (m_mode == 0) || (((m_edit_n / BLINK_DIV) % 2) == 0);
  endfunction

  task automatic model_update(input logic mb, input logic ib, input logic r);
    logic me;
    logic ie;
    if (r) begin
      m_mode = 0; m_run_n = 0; m_edit_n = 0; m_press = -1;
      m_pm = 1'b1; m_pi = 1'b1;
    end else begin
      me = mb && !m_pm;
      ie = ib && !m_pi;
      if (me) begin
        m_mode = (m_mode + 1) % 4;
        m_run_n = 0; m_edit_n = 0; m_press = -1;
      end else begin
        m_run_n++;
        m_edit_n++;
        if (m_mode == 0)              m_press = -1;
        else if (ie)                  m_press = 1;
        else if (ib && m_press > 0)   m_press++;
        else                          m_press = -1;
      end
      m_pm = mb;
      m_pi = ib;
    end
  endtask

  task automatic check_outputs();
    check("mode",      bus.Mode,        64'(m_mode));
    check("edit_h",    bus.EditHours,   m_mode == 1);
    check("edit_m",    bus.EditMinutes, m_mode == 2);
    check("edit_s",    bus.EditSeconds, m_mode == 3);
    check("sec_tick",  bus.SecTick,     exp_tick());
    check("increment", bus.Increment,   exp_inc());
    check("blink",     bus.Blink,       exp_blink());
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, compare on the next falling edge.
  task automatic step(input logic mb, input logic ib, input logic r);
    bus.ModeBtn = mb;
    bus.IncBtn  = ib;
    RST         = r;
    @(posedge CLK);
    model_update(mb, ib, r);
    @(negedge CLK);
    check_outputs();
  endtask

  initial begin
    logic [63:0] mask;
    logic        inc_any;
    logic        mb;
    logic        ib;
    logic        r;
    logic [1:0]  seq [4];
    seq = '{2'b01, 2'b10, 2'b11, 2'b00};

    m_mode = 0; m_run_n = 0; m_edit_n = 0; m_press = -1; m_pm = 1'b1; m_pi = 1'b1;
    bus.ModeBtn = 1'b0; bus.IncBtn = 1'b0; RST = 1'b1;

    // Reset with buttons low
    step(0, 0, 1);
    step(0, 0, 1);
    check("rst_blink", bus.Blink, 1'b1);

    // RUN: the first cycle after reset is cycle 1 (prescaler 0)
    mask = '0; inc_any = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      step(0, 0, 0);
      if (bus.SecTick)   mask[k+1] = 1'b1;
      if (bus.Increment) inc_any   = 1'b1;
    end
    check("run_ticks", mask, (64'd1 << 10) | (64'd1 << 20) | (64'd1 << 30));
    check("run_no_inc", inc_any, 1'b0);

    // Four mode presses cycle through all edit states back to RUN
    for (int p = 0; p < 4; p++) begin
      step(1, 0, 0);
      check("mode_seq", bus.Mode, seq[p]);
      if (p < 3) begin
        step(0, 0, 0);
        step(0, 0, 0);
      end
    end
    mask = '0;
    for (int j = 1; j <= 12; j++) begin
      step(0, 0, 0);
      if (bus.SecTick) mask[j+1] = 1'b1;
    end
    check("rerun_tick", mask, 64'd1 << 10);

    // EDIT_M: hold IncBtn for 20 cycles
    step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    check("in_edit_m", bus.Mode, 2'b10);
    mask = '0;
    for (int k = 1; k <= 26; k++) begin
      step(0, (k <= 20), 0);
      if (bus.Increment) mask[k] = 1'b1;
    end
    check("repeat_pattern", mask,
          (64'd1 << 1) | (64'd1 << 9) | (64'd1 << 12) | (64'd1 << 15) | (64'd1 << 18));

    // EDIT_H: ModeBtn and IncBtn rise together
    step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    check("in_edit_h", bus.Mode, 2'b01);
    inc_any = 1'b0;
    step(1, 1, 0);
    check("coincide_mode", bus.Mode, 2'b10);
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 0);
      if (bus.Increment) inc_any = 1'b1;
    end
    check("coincide_no_inc", inc_any, 1'b0);
    step(0, 0, 0);

    // EDIT_S with IncBtn held, then reset
    step(1, 0, 0); step(0, 0, 0);
    check("in_edit_s", bus.Mode, 2'b11);
    for (int k = 0; k < 4; k++) step(0, 1, 0);
    step(0, 1, 1);
    check("rst_mid_mode", bus.Mode, 2'b00);
    check("rst_mid_blink", bus.Blink, 1'b1);
    check("rst_mid_inc", bus.Increment, 1'b0);
    inc_any = 1'b0;
    step(0, 1, 0);
    step(1, 1, 0);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0);
      if (bus.Increment) inc_any = 1'b1;
    end
    check("held_after_rst", inc_any, 1'b0);
    step(0, 0, 0);

    // ModeBtn held through reset must not count as a press
    step(1, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    check("mode_held_rst", bus.Mode, 2'b00);
    step(0, 0, 0);

    // EDIT_H idle: blink pattern from the entry cycle
    step(1, 0, 0);
    mask = '0;
    if (bus.Blink) mask[0] = 1'b1;
    for (int k = 1; k < 16; k++) begin
      step(0, 0, 0);
      if (bus.Blink) mask[k] = 1'b1;
    end
    check("blink_pattern", mask, 64'h0F0F);

    // Random button activity with occasional reset
    mb = 1'b0; ib = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0)  mb = ~mb;
      if ($urandom_range(0, 13) == 0) ib = ~ib;
      r = ($urandom_range(0, 299) == 0);
      step(mb, ib, r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 Parameter CLK_DIV, 100000000, CLK cycles per SecTick pulse; legal range 2 to 2^27.
REQ-002 Parameter REPEAT_DLY, 50000000, IncBtn hold cycles before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PER, 12500000, cycles between subsequent auto-repeat pulses.
REQ-004 Parameter BLINK_DIV, 25000000, cycles per Blink half-period.
REQ-005 CLK  in  1  single system clock; all state updates on its rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 ModeBtn  in  1  mode button level, already synchronized and debounced.
REQ-008 IncBtn  in  1  increment button level, already synchronized and debounced.
REQ-009 SecTick  out  1  one-cycle pulse into the seconds counter InTick input.
REQ-010 EditHours, EditMinutes, EditSeconds  out  1 each  EditEnable for the matching digit counter; at most one is high.
REQ-011 Increment  out  1  one-cycle increment pulse, shared by all digit counters.
REQ-012 Blink  out  1  display-enable for the field being edited; 1 = visible.
REQ-013 Mode  out  2  current state encoding.

Function
REQ-014 FSM states: RUN=00, EDIT_H=01, EDIT_M=10, EDIT_S=11; Mode shall equal the state register.
REQ-015 A ModeBtn rising edge is defined as the current sample = 1 and the previous sample = 0; it shall advance RUN->EDIT_H->EDIT_M->EDIT_S->RUN, with the new state visible one cycle later.
REQ-016 Edit outputs shall be decoded from the registered state: EditHours=(EDIT_H), EditMinutes=(EDIT_M), EditSeconds=(EDIT_S).
REQ-017 In RUN, the prescaler shall count 0..CLK_DIV-1 and wrap; SecTick shall be high for exactly the cycle in which the count equals CLK_DIV-1.
REQ-018 In any edit state, the prescaler shall be held at 0 and SecTick shall be 0.
REQ-019 On the EDIT_S->RUN transition, the prescaler shall restart at 0, so the first SecTick occurs CLK_DIV cycles after Mode becomes RUN.
REQ-020 In an edit state, an IncBtn rising edge shall produce Increment high for exactly the following cycle.
REQ-021 While IncBtn stays high in an edit state, Increment shall pulse REPEAT_DLY cycles after the edge pulse, then every REPEAT_PER cycles until IncBtn falls.
REQ-022 When IncBtn falls, the repeat counter shall clear immediately and no further pulse shall be issued.
REQ-023 In RUN, IncBtn shall be ignored: no Increment pulse and the repeat counter is held at 0.
REQ-024 If a ModeBtn edge and an IncBtn edge (or a due repeat pulse) coincide, the mode change wins: no Increment pulse and the repeat counter clears.
REQ-025 A held IncBtn across a mode change shall not generate pulses in the new state until it is released and pressed again.
REQ-026 In edit states, Blink shall toggle every BLINK_DIV cycles; on entry to any edit state, Blink shall be set to 1 and the blink counter to 0.
REQ-027 In RUN, Blink shall be 1.
REQ-028 All outputs shall be registered except the Edit* and Mode decodes of the state register.

Reset
REQ-029 On RST=1 at a CLK edge: state=RUN, prescaler=0, repeat and blink counters=0, SecTick=0, Increment=0, Blink=1.
REQ-030 On reset, both button-history registers shall be set to 1, so a button held through reset produces no edge.
REQ-031 RST asserted mid-edit or mid-repeat shall take priority over every other event in the same cycle.

Structure
REQ-032 Package clock_ctrl_pkg shall hold the state encodings RUN/EDIT_H/EDIT_M/EDIT_S and the default parameter values.
REQ-033 Counter widths shall be derived from their parameters using clog2.
REQ-034 Edge detection plus hold/repeat timing shall be a single sub-module, btn_autorepeat, instantiated once for IncBtn with an enable input and a clear input.

Verification (bench parameters: CLK_DIV=10, REPEAT_DLY=8, REPEAT_PER=3, BLINK_DIV=4)
REQ-035 Release reset with buttons low, run 35 cycles in RUN -> SecTick pulses at cycles 10, 20 and 30 after reset release; Increment stays 0 throughout.
REQ-036 Press ModeBtn 4 times -> Mode sequence 01, 10, 11, 00; exactly one Edit* output high per edit state; SecTick stays 0 while editing; first SecTick 10 cycles after return to RUN.
REQ-037 In EDIT_M, hold IncBtn for 20 cycles -> Increment pulses at cycles 1, 9, 12, 15 and 18 after the edge; none after release.
REQ-038 Raise ModeBtn and IncBtn in the same cycle in EDIT_H -> Mode becomes 10 and no Increment pulse occurs.
REQ-039 Assert RST during EDIT_S with IncBtn held -> next cycle Mode=00, Blink=1, Increment=0; no edge is detected after release of RST while IncBtn is still held.
REQ-040 In EDIT_H idle -> Blink pattern 1,1,1,1,0,0,0,0 repeating from the entry cycle.
